muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit for the MIPS core, owning the HI/LO register pair. It consumes the 6-bit ALU function code produced by the ALU control decoder and acts on the R-type multiply, divide and HI/LO move functions: MULT, MULTU, DIV, DIVU, MTHI and MTLO. The core's execute stage issues a `start` pulse and stalls on `busy`. MFHI and MFLO read the `hi` and `lo` outputs directly.

## Interface

- `DIV0_LO`, default 32'hFFFF_FFFF: value written to LO on any divide by zero.

- `clk`  in  1  single clock; all state updates on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  issue request, sampled on the rising edge
- `fncode`  in  6  function code: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MTHI 0x11, MTLO 0x13
- `op_a`  in  32  rs value (dividend / multiplicand / MTxx source)
- `op_b`  in  32  rt value (divisor / multiplier)
- `busy`  out  1  operation in flight; the core stalls MF/MT/mul/div while high
- `done`  out  1  one-cycle pulse; HI/LO hold the new result in this cycle
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation

- **Reset values:** all outputs 0, FSM in IDLE, counter 0.
- **FSM states:** IDLE, RUN, FIX.
- **IDLE, `start`=1 with MULT/MULTU/DIV/DIVU:**
  - Latch operand magnitudes. Signed ops take the absolute value; unsigned ops take the operand unchanged.
  - Latch result signs: product/quotient sign = sa^sb; remainder sign = sa.
  - Clear the 64-bit accumulator and the 5-bit counter; go to RUN.
- **IDLE, `start`=1 with MTHI/MTLO:** write `op_a` to `hi`/`lo` at that edge. FSM stays in IDLE; no `busy`, no `done`.
- **IDLE, `start`=1 with any other fncode:** ignored; no state change.
- **RUN, multiply:** radix-2 shift-add, one multiplier bit per cycle.
- **RUN, divide:** restoring division, one quotient bit per cycle.
- **RUN, exit:** the counter increments each cycle; after 32 iterations (counter wraps 31→0), go to FIX.
- **FIX, multiply:** apply the sign. Negation is two's complement over the full 64 bits. HI = upper 32 bits, LO = lower 32 bits. Assert `done`; return to IDLE.
- **FIX, divide:** LO = quotient with its sign applied; HI = remainder with its sign applied. Assert `done`; return to IDLE.
- **Divide by zero (`op_b`=0):** runs the full latency, then HI = `op_a` (unmodified) and LO = `DIV0_LO`, for both DIV and DIVU.
- **DIV 0x80000000 / 0xFFFFFFFF:** LO = 0x80000000, HI = 0. No trap.
- **`start` while `busy`=1:** ignored, including MTHI/MTLO. The core guarantees a stall; the unit does not queue requests.
- **`reset_n` low at any time:** returns the FSM to IDLE immediately and clears HI/LO. The in-flight result is discarded.

## Timing

- Start accepted at edge E0. `busy` is high from just after E0 until just after E33 (33 cycles).
- RUN occupies edges E1–E32. FIX occupies E33.
- `hi`/`lo` update at E33. `done` is high for the single cycle following E33. `busy` is low in that same cycle, so a new `start` may be accepted at E34.
- MTHI/MTLO latency is 1 edge.
- `hi`/`lo` are registered outputs; MF reads are combinational from them.

## Configuration

- `MULDIV_FAST_MULT_EN` defined:
  - MULT/MULTU compute the full 64-bit signed/unsigned product in a single cycle. FSM goes IDLE→FIX and skips RUN.
  - `busy` is high for 1 cycle; `done` is high in the cycle after E1.
  - Divide timing is unchanged.
- `MULDIV_FAST_MULT_EN` undefined: multiply uses the 33-cycle iterative path described above.

## Test plan

- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; `done` exactly 33 cycles after start (1 cycle with `MULDIV_FAST_MULT_EN`); `busy` low in the `done` cycle.
- MULT 0xFFFFFFFD (−3) × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; then MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- DIV 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7 / 2 → LO=3, HI=1; DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 5 / 0 → HI=5, LO=0xFFFFFFFF after 33 cycles.
- MTHI 0x1234 in IDLE → `hi`=0x1234 next cycle, `busy` stays 0. Start DIVU; at cycle 5 issue MTLO 0xABCD → `lo` unchanged and the divide result is unaffected.
- Start MULTU; deassert `reset_n` at cycle 10 → `busy`, `hi`, `lo` go to 0 without waiting for an edge; no `done` pulse. After release, a fresh MULTU 3 × 4 → LO=12, HI=0.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the execute stage and muldiv_unit.
// The core drives the request side and reads HI/LO and status back.
interface muldiv_unit_if;
    logic        start;
    logic [5:0]  fncode;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, fncode, op_a, op_b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, fncode, op_a, op_b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO (shift-add, restoring div).
// Define MULDIV_FAST_MULT_EN for a single-cycle multiplier.
module muldiv_unit #(
    parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
    input  logic    clk,
    input  logic    reset_n,
    muldiv_unit_if.slave bus
);
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state, state_nx;
    logic        is_mul, is_div, is_sgn, is_mthi, is_mtlo;
    logic        accept;
    logic [31:0] abs_a, abs_b;

    logic [63:0] acc;
    logic [31:0] dv;
    logic [31:0] sh;
    logic [31:0] a_raw;
    logic [4:0]  cnt;
    logic        op_div, sign_q, sign_r, div0;
    logic [31:0] hi_q, lo_q;
    logic        done_q;

    logic [32:0] mul_sum;
    logic [63:0] mul_nx;
    logic [32:0] div_sft;
    logic [33:0] div_dif;
    logic        div_ok;
    logic [63:0] div_nx;
    logic [63:0] prod;

    always_comb begin
        is_mul  = 1'b0;
        is_div  = 1'b0;
        is_sgn  = 1'b0;
        is_mthi = 1'b0;
        is_mtlo = 1'b0;
        unique case (bus.fncode)
            F_MULT:  begin is_mul = 1'b1; is_sgn = 1'b1; end
            F_MULTU: is_mul = 1'b1;
            F_DIV:   begin is_div = 1'b1; is_sgn = 1'b1; end
            F_DIVU:  is_div = 1'b1;
            F_MTHI:  is_mthi = 1'b1;
            F_MTLO:  is_mtlo = 1'b1;
            default: ;
        endcase
    end

    assign accept = bus.start && (state == IDLE);
    assign abs_a  = (is_sgn && bus.op_a[31]) ? -bus.op_a : bus.op_a;
    assign abs_b  = (is_sgn && bus.op_b[31]) ? -bus.op_b : bus.op_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept && (is_mul || is_div)) begin
`ifdef MULDIV_FAST_MULT_EN
                    state_nx = is_mul ? FIX : RUN;
`else
                    state_nx = RUN;
`endif
                end
            end
            RUN:     if (cnt == 5'd31) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Multiply: partial product in acc[63:32], multiplier bits shift out of sh.
    assign mul_sum = {1'b0, acc[63:32]} + (sh[0] ? {1'b0, dv} : 33'd0);
    assign mul_nx  = {mul_sum, acc[31:1]};

    // Divide: remainder in acc[63:32], quotient grows in acc[31:0].
    assign div_sft = {acc[63:32], sh[31]};
    assign div_dif = {1'b0, div_sft} - {2'b00, dv};
    assign div_ok  = !div_dif[33];
    assign div_nx  = {div_ok ? div_dif[31:0] : div_sft[31:0],
                      acc[30:0], div_ok};

    assign prod = sign_q ? -acc : acc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= '0;
            dv     <= '0;
            sh     <= '0;
            a_raw  <= '0;
            cnt    <= '0;
            op_div <= 1'b0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            div0   <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == FIX);
            unique case (state)
                IDLE: begin
                    if (accept && is_mthi) hi_q <= bus.op_a;
                    if (accept && is_mtlo) lo_q <= bus.op_a;
                    if (accept && (is_mul || is_div)) begin
                        op_div <= is_div;
                        sign_q <= is_sgn && (bus.op_a[31] ^ bus.op_b[31]);
                        sign_r <= is_sgn && bus.op_a[31];
                        div0   <= (bus.op_b == 32'd0);
                        a_raw  <= bus.op_a;
                        dv     <= is_div ? abs_b : abs_a;
                        sh     <= is_div ? abs_a : abs_b;
                        cnt    <= '0;
`ifdef MULDIV_FAST_MULT_EN
                        acc    <= is_mul ? 64'(abs_a) * 64'(abs_b) : '0;
`else
                        acc    <= '0;
`endif
                    end
                end
                RUN: begin
                    acc <= op_div ? div_nx : mul_nx;
                    sh  <= op_div ? (sh << 1) : (sh >> 1);
                    cnt <= cnt + 5'd1;
                end
                FIX: begin
                    if (!op_div) begin
                        hi_q <= prod[63:32];
                        lo_q <= prod[31:0];
                    end else if (div0) begin
                        hi_q <= a_raw;
                        lo_q <= DIV0_LO;
                    end else begin
                        hi_q <= sign_r ? -acc[63:32] : acc[63:32];
                        lo_q <= sign_q ? -acc[31:0] : acc[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit.
// Expected HI/LO values and latencies are hand-computed.
module tb_muldiv_unit;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam int DIV_LAT = 33;
`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;

    muldiv_unit_if bus();

    muldiv_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.fncode = fn;
        bus.op_a   = a;
        bus.op_b   = b;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.done && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [5:0] fn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int lat);
        int n;
        issue(fn, a, b);
        chk({tag, ".busy_hi"}, 32'(bus.busy), 32'd1);
        wait_done(n);
        chk({tag, ".lat"}, n, lat);
        chk({tag, ".busy_lo"}, 32'(bus.busy), 32'd0);
        chk({tag, ".hi"}, bus.hi, exp_hi);
        chk({tag, ".lo"}, bus.lo, exp_lo);
    endtask

    initial begin
        int n;
        int seen;
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        bus.start   = 1'b0;
        bus.fncode  = '0;
        bus.op_a    = '0;
        bus.op_b    = '0;

        repeat (2) @(negedge clk);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.hi", bus.hi, 32'd0);
        chk("rst.lo", bus.lo, 32'd0);
        reset_n = 1'b1;

        run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
        run_op("mult_neg", F_MULT, 32'hFFFF_FFFD, 32'd7,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT);
        run_op("mult_min", F_MULT, 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, 32'h0000_0000, MUL_LAT);
        run_op("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
        run_op("divu_7_2", F_DIVU, 32'd7, 32'd2,
               32'd1, 32'd3, DIV_LAT);
        run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h8000_0000, DIV_LAT);
        run_op("divu_z", F_DIVU, 32'd5, 32'd0,
               32'd5, 32'hFFFF_FFFF, DIV_LAT);
        run_op("div_z", F_DIV, 32'hFFFF_FFF0, 32'd0,
               32'hFFFF_FFF0, 32'hFFFF_FFFF, DIV_LAT);

        issue(F_MTHI, 32'h0000_1234, 32'd0);
        chk("mthi.hi", bus.hi, 32'h0000_1234);
        chk("mthi.busy", 32'(bus.busy), 32'd0);
        chk("mthi.lo", bus.lo, 32'hFFFF_FFFF);

        // MTLO issued mid-divide must be dropped.
        issue(F_DIVU, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        bus.start  = 1'b1;
        bus.fncode = F_MTLO;
        bus.op_a   = 32'h0000_ABCD;
        @(negedge clk);
        bus.start  = 1'b0;
        chk("mtlo_busy.lo", bus.lo, 32'hFFFF_FFFF);
        wait_done(n);
        chk("mtlo_busy.to", 32'(n < 100), 32'd1);
        chk("mtlo_busy.hi_res", bus.hi, 32'd2);
        chk("mtlo_busy.lo_res", bus.lo, 32'd14);

        // Asynchronous reset in the middle of a multiply.
        issue(F_MULTU, 32'd9, 32'd9);
        repeat (8) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst.busy", 32'(bus.busy), 32'd0);
        chk("arst.hi", bus.hi, 32'd0);
        chk("arst.lo", bus.lo, 32'd0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        reset_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        chk("arst.no_done", seen, 32'd0);
        chk("arst.lo_hold", bus.lo, 32'd0);

        run_op("multu_3_4", F_MULTU, 32'd3, 32'd4,
               32'd0, 32'd12, MUL_LAT);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
